// File: rtl/psm_pkg.sv
// ---------------------------------------------------------------------------
// psm_pkg
// Shared definitions for the PSM synchronisation generator:
//   - default carrier counter width and minimum carrier period
//   - SPS word width (sign-magnitude, bit 15 = sign)
//   - conversions between sign-magnitude SPS words and 17-bit two's complement
//   - run-state encoding of the generator
// ---------------------------------------------------------------------------
package psm_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int SPS_W      = 16;
  localparam int MIN_PERIOD = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } psm_state_t;

  // Negative zero maps to 0, so the result is always a clean two's-complement value.
  function automatic logic signed [SPS_W:0] sm_to_tc(input logic [SPS_W-1:0] sm);
    logic signed [SPS_W:0] mag;
    mag = {2'b00, sm[SPS_W-2:0]};
    return sm[SPS_W-1] ? -mag : mag;
  endfunction

  // A zero value always comes back with sign 0.
  function automatic logic [SPS_W-1:0] tc_to_sm(input logic signed [SPS_W:0] tc);
    logic [SPS_W-2:0] mag;
    mag = (SPS_W-1)'(tc[SPS_W] ? -tc : tc);
    return {tc[SPS_W], mag};
  endfunction

endpackage

// File: rtl/psm_carrier_counter.sv
// ---------------------------------------------------------------------------
// psm_carrier_counter
// One carrier counter: counts 0 .. i_period-1 and wraps, with a load port
// that takes priority over counting. The sync pulse is registered and is
// high in the cycle the count register holds 0, gated by i_pulse_en.
//
// Ports
//   i_clk       clock
//   i_load      load i_load_val on the next edge (priority over counting)
//   i_load_val  value to load
//   i_cnt_en    advance the counter
//   i_pulse_en  allow the sync pulse
//   i_period    carrier period in cycles (>= 2)
//   o_cnt       current count
//   o_sync      one-cycle pulse while o_cnt == 0
//   o_wrap      combinational: counter wraps on the coming edge
// ---------------------------------------------------------------------------
module psm_carrier_counter
  import psm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_cnt_en,
  input  logic             i_pulse_en,
  input  logic [CNT_W-1:0] i_period,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sync,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync;
  logic             w_at_end;

  // ">=" keeps the counter bounded even if it ever sits above the period.
  assign w_at_end = (r_cnt >= (i_period - ONE));
  assign o_wrap   = i_cnt_en & w_at_end;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (i_cnt_en) begin
      w_cnt_nxt = w_at_end ? '0 : (r_cnt + ONE);
    end
  end

  always_ff @(posedge i_clk) begin
    r_cnt  <= w_cnt_nxt;
    r_sync <= i_pulse_en & (w_cnt_nxt == '0);
  end

  assign o_cnt  = r_cnt;
  assign o_sync = r_sync;

endmodule

// File: rtl/psm_sync_generator.sv
// ---------------------------------------------------------------------------
// psm_sync_generator
// Carrier / synchronisation source for the phase-shift modulator. Two
// carrier counters share a shadowed period; carrier 2 is re-aligned to the
// shadowed phase at every carrier 1 wrap. The sign-magnitude SPS setpoint
// is updated only on carrier 1 sync pulses.
//
// Configuration macro: PSM_SYNC_SLEW_EN
//   defined   -> SPS value moves toward the target by at most SPS_STEP per period
//   undefined -> SPS value takes the target directly at each carrier 1 sync
//
// Ports
//   CLK          200 MHz clock
//   RST          synchronous active-high reset (priority over iENABLE)
//   iENABLE      run the carriers; low returns to reset state (SPS held)
//   iPERIOD      carrier period in cycles (clamped to >= 2)
//   iPHASE       carrier 2 offset in cycles (clamped to period-1)
//   iSPS_target  requested SPS, sign-magnitude
//   oSych1       pulse while oCNT1 == 0
//   oSych2       pulse while oCNT2 == 0
//   oCNT1/oCNT2  carrier counts
//   oSPS_value   applied SPS, sign-magnitude
//   oSPS_sign    oSPS_value[15]
// ---------------------------------------------------------------------------
module psm_sync_generator
  import psm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SPS_STEP = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iENABLE,
  input  logic [CNT_W-1:0] iPERIOD,
  input  logic [CNT_W-1:0] iPHASE,
  input  logic [SPS_W-1:0] iSPS_target,
  output logic             oSych1,
  output logic             oSych2,
  output logic [CNT_W-1:0] oCNT1,
  output logic [CNT_W-1:0] oCNT2,
  output logic [SPS_W-1:0] oSPS_value,
  output logic             oSPS_sign
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(MIN_PERIOD);

  if (SPS_STEP < 1) begin : g_bad_step
    $error("SPS_STEP must be at least 1");
  end

  psm_state_t r_state;
  psm_state_t w_state_nxt;
  logic       w_start;
  logic       w_run;
  logic       r_en_d;

  logic [CNT_W-1:0] r_per_q;
  logic [CNT_W-1:0] r_ph_q;
  logic [CNT_W-1:0] w_per_c;
  logic [CNT_W-1:0] w_ph_c;
  logic [CNT_W-1:0] w_ph_ld;
  logic             w_sh_load;

  logic             w_car_load;
  logic             w_pulse_en;
  logic             w_wrap1;
  logic             w_wrap2;

  logic [SPS_W-1:0]        r_sps;
  logic [SPS_W-1:0]        w_sps_nxt;
  logic signed [SPS_W:0]   w_tgt_tc;
  logic                    w_sps_upd;

  // Run-state FSM. RST and a low iENABLE both force the idle (reset) state;
  // the first enabled edge out of idle is the carrier start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
    r_en_d <= iENABLE;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_run       = 1'b0;
    if (RST) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iENABLE) begin
            w_state_nxt = ST_RUN;
            w_start     = 1'b1;
          end
        end
        ST_RUN: begin
          if (iENABLE) begin
            w_run = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Input clamping and shadow registers. The shadows only move on reset,
  // on an iENABLE rising edge, or at a carrier 1 wrap, so a period in
  // progress always completes with the settings it started with.
  assign w_per_c   = (iPERIOD < PER_MIN) ? PER_MIN : iPERIOD;
  assign w_ph_c    = (iPHASE > (w_per_c - ONE)) ? (w_per_c - ONE) : iPHASE;
  assign w_sh_load = RST | (iENABLE & ~r_en_d) | w_wrap1;
  assign w_ph_ld   = w_sh_load ? w_ph_c : r_ph_q;

  always_ff @(posedge CLK) begin
    if (w_sh_load) begin
      r_per_q <= w_per_c;
      r_ph_q  <= w_ph_c;
    end
  end

  // Both carriers are (re)loaded whenever they are not counting (reset,
  // disabled, start) and at each carrier 1 wrap; carrier 2 picks up the
  // phase that is being shadowed on that same edge.
  assign w_car_load = ~w_run | w_wrap1;
  assign w_pulse_en = iENABLE & ~RST;

  psm_carrier_counter #(.CNT_W(CNT_W)) u_car1 (
    .i_clk      (CLK),
    .i_load     (w_car_load),
    .i_load_val ('0),
    .i_cnt_en   (w_run),
    .i_pulse_en (w_pulse_en),
    .i_period   (r_per_q),
    .o_cnt      (oCNT1),
    .o_sync     (oSych1),
    .o_wrap     (w_wrap1)
  );

  psm_carrier_counter #(.CNT_W(CNT_W)) u_car2 (
    .i_clk      (CLK),
    .i_load     (w_car_load),
    .i_load_val (w_ph_ld),
    .i_cnt_en   (w_run),
    .i_pulse_en (w_pulse_en),
    .i_period   (r_per_q),
    .o_cnt      (oCNT2),
    .o_sync     (oSych2),
    .o_wrap     (w_wrap2)
  );

  // Carrier 2 wrap is only observed through its sync pulse.
  logic w_wrap2_unused;
  assign w_wrap2_unused = w_wrap2;

  // SPS setpoint: updated on the same edges that raise oSych1.
  assign w_sps_upd = w_start | w_wrap1;
  assign w_tgt_tc  = sm_to_tc(iSPS_target);

`ifdef PSM_SYNC_SLEW_EN
  localparam logic signed [SPS_W+1:0] STEP_S = (SPS_W+2)'(SPS_STEP);

  // Move cur toward tgt by at most STEP_S; the extra bit keeps the
  // difference of two 17-bit values from overflowing.
  function automatic logic signed [SPS_W:0] sps_slew(input logic signed [SPS_W:0] cur,
                                                     input logic signed [SPS_W:0] tgt);
    logic signed [SPS_W+1:0] cur_x;
    logic signed [SPS_W+1:0] tgt_x;
    logic signed [SPS_W+1:0] diff;
    logic signed [SPS_W+1:0] res;
    cur_x = (SPS_W+2)'(cur);
    tgt_x = (SPS_W+2)'(tgt);
    diff  = tgt_x - cur_x;
    if (diff > STEP_S) begin
      res = cur_x + STEP_S;
    end else if (diff < -STEP_S) begin
      res = cur_x - STEP_S;
    end else begin
      res = tgt_x;
    end
    return res[SPS_W:0];
  endfunction

  logic signed [SPS_W:0] w_cur_tc;
  assign w_cur_tc  = sm_to_tc(r_sps);
  assign w_sps_nxt = tc_to_sm(sps_slew(w_cur_tc, w_tgt_tc));
`else
  assign w_sps_nxt = tc_to_sm(w_tgt_tc);
`endif

  // Disable holds the setpoint; only RST clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sps <= '0;
    end else if (w_sps_upd) begin
      r_sps <= w_sps_nxt;
    end
  end

  assign oSPS_value = r_sps;
  assign oSPS_sign  = r_sps[SPS_W-1];

endmodule

// File: tb/tb_psm_sync_generator.sv
// ---------------------------------------------------------------------------
// tb_psm_sync_generator
// Self-checking bench: table of period/phase configurations, hand-written
// sequences (shadowing, SPS stepping, reset/disable), and a randomized run
// compared every cycle against a behavioural model of the carriers.
// ---------------------------------------------------------------------------
module tb_psm_sync_generator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iENABLE;
  logic [15:0] iPERIOD;
  logic [15:0] iPHASE;
  logic [15:0] iSPS_target;
  logic        oSych1;
  logic        oSych2;
  logic [15:0] oCNT1;
  logic [15:0] oCNT2;
  logic [15:0] oSPS_value;
  logic        oSPS_sign;

  psm_sync_generator #(.CNT_W(16), .SPS_STEP(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .iENABLE     (iENABLE),
    .iPERIOD     (iPERIOD),
    .iPHASE      (iPHASE),
    .iSPS_target (iSPS_target),
    .oSych1      (oSych1),
    .oSych2      (oSych2),
    .oCNT1       (oCNT1),
    .oCNT2       (oCNT2),
    .oSPS_value  (oSPS_value),
    .oSPS_sign   (oSPS_sign)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: time within the current carrier period plus the
  // settings that period runs with.
  bit          m_run    = 1'b0;
  bit          m_en_d   = 1'b0;
  bit          m_rstedg = 1'b0;
  int          m_t      = 0;
  int          m_per    = 2;
  int          m_ph     = 0;
  int          m_sps    = 0;
  logic [15:0] prev_sps = '0;
  bit          prev_ok  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sm_val(input logic [15:0] v);
    int mag;
    mag = int'(v[14:0]);
    return v[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] sm_enc(input int s);
    logic [14:0] mag;
    if (s < 0) begin
      mag = 15'(-s);
      return {1'b1, mag};
    end
    mag = 15'(s);
    return {1'b0, mag};
  endfunction

  function automatic int sps_next(input int cur, input int tgt);
`ifdef PSM_SYNC_SLEW_EN
    if (tgt - cur > 16) return cur + 16;
    if (tgt - cur < -16) return cur - 16;
    return tgt;
`else
    return cur - cur + tgt;
`endif
  endfunction

  task automatic model_step();
    int cp;
    int cph;
    cp  = (int'(iPERIOD) < 2) ? 2 : int'(iPERIOD);
    cph = (int'(iPHASE) > cp - 1) ? cp - 1 : int'(iPHASE);
    m_rstedg = RST;
    if (RST) begin
      m_run = 1'b0; m_per = cp; m_ph = cph; m_sps = 0;
    end else if (!iENABLE) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (!m_en_d) begin m_per = cp; m_ph = cph; end
      m_run = 1'b1; m_t = 0;
      m_sps = sps_next(m_sps, sm_val(iSPS_target));
    end else if (m_t == m_per - 1) begin
      m_per = cp; m_ph = cph; m_t = 0;
      m_sps = sps_next(m_sps, sm_val(iSPS_target));
    end else begin
      m_t++;
    end
    m_en_d = iENABLE;
  endtask

  // One clock: step the model on the edge, compare all outputs 1 time unit later.
  task automatic tick();
    int c2;
    @(posedge CLK);
    model_step();
    #1;
    c2 = m_run ? (m_ph + m_t) % m_per : m_ph;
    check("cnt1",  int'(oCNT1), m_run ? m_t : 0);
    check("cnt2",  int'(oCNT2), c2);
    check("sych1", int'(oSych1), int'(m_run && m_t == 0));
    check("sych2", int'(oSych2), int'(m_run && c2 == 0));
    check("sps",   int'(oSPS_value), int'(sm_enc(m_sps)));
    check("sps_sign", int'(oSPS_sign), int'(m_sps < 0));
    if (prev_ok && !m_rstedg)
      check("sps_change_outside_sych1", int'((oSPS_value != prev_sps) && !oSych1), 0);
    prev_sps = oSPS_value;
    prev_ok  = 1'b1;
  endtask

  task automatic wait_sych1(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!oSych1 && n < limit);
    if (!oSych1) check("sych1_timeout", int'(oSych1), 1);
  endtask

  task automatic wait_cnt1(input int value, input int limit);
    int n;
    n = 0;
    while (int'(oCNT1) != value && n < limit) begin
      tick();
      n++;
    end
    if (int'(oCNT1) != value) check("cnt1_wait_timeout", int'(oCNT1), value);
  endtask

  typedef struct {
    int per_in;
    int ph_in;
    int exp_per;
    int exp_ph;
  } vec_t;

  vec_t        vt[7];
  logic [15:0] sps_tgt[7];
  logic [15:0] sps_exp[7];

  initial begin
    int n;
    int last;
    int off;
    int pulses;

    vt[0] = '{4000, 2000, 4000, 2000};
    vt[1] = '{0,    0,    2,    0};
    vt[2] = '{1,    0,    2,    0};
    vt[3] = '{100,  150,  100,  99};
    vt[4] = '{10,   0,    10,   0};
    vt[5] = '{7,    3,    7,    3};
    vt[6] = '{2,    5,    2,    1};

    sps_tgt = '{16'h8020, 16'h8020, 16'h8020, 16'h0008, 16'h0008, 16'h0008, 16'h8000};
`ifdef PSM_SYNC_SLEW_EN
    sps_exp = '{16'h8010, 16'h8020, 16'h8020, 16'h8010, 16'h0000, 16'h0008, 16'h0000};
`else
    sps_exp = '{16'h8020, 16'h8020, 16'h8020, 16'h0008, 16'h0008, 16'h0008, 16'h0000};
`endif

    RST = 1'b1; iENABLE = 1'b1; iPERIOD = 16'd4; iPHASE = 16'd0; iSPS_target = 16'h0000;

    // Period / phase table, including clamping and zero phase.
    for (int i = 0; i < 7; i++) begin
      RST = 1'b1;
      iPERIOD = 16'(vt[i].per_in);
      iPHASE  = 16'(vt[i].ph_in);
      tick();
      check("reset_cnt1",  int'(oCNT1), 0);
      check("reset_cnt2",  int'(oCNT2), vt[i].exp_ph);
      check("reset_sych1", int'(oSych1), 0);
      check("reset_sps",   int'(oSPS_value), 0);
      RST = 1'b0;
      tick();
      check("first_sych1", int'(oSych1), 1);
      n = 0; last = 0;
      do begin
        last = int'(oCNT1);
        tick();
        n++;
      end while (!oSych1 && n < 70000);
      check("period", n, vt[i].exp_per);
      check("wrap_from", last, vt[i].exp_per - 1);
      off = 0;
      while (!oSych2 && off < 70000) begin
        tick();
        off++;
      end
      check("sych2_offset", off, (vt[i].exp_ph == 0) ? 0 : vt[i].exp_per - vt[i].exp_ph);
    end

    // Shadowing: a period change mid-period takes effect at the next wrap.
    RST = 1'b1; iPERIOD = 16'd4000; iPHASE = 16'd2000;
    tick();
    RST = 1'b0;
    tick();
    wait_cnt1(500, 1000);
    iPERIOD = 16'd1000; iPHASE = 16'd200;
    wait_sych1(70000, n);
    check("shadow_old_period_rest", n, 3500);
    wait_sych1(70000, n);
    check("shadow_new_period", n, 1000);
    wait_sych1(70000, n);
    check("shadow_new_period_2", n, 1000);

    // SPS stepping on successive sync pulses.
    RST = 1'b1; iPERIOD = 16'd4; iPHASE = 16'd0; iSPS_target = 16'h0000;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 7; k++) begin
      iSPS_target = sps_tgt[k];
      wait_sych1(10, n);
      check("sps_step", int'(oSPS_value), int'(sps_exp[k]));
    end

    // Reset mid-operation, then disable.
    RST = 1'b1; iPERIOD = 16'd4000; iPHASE = 16'd2000; iSPS_target = 16'h0005;
    tick();
    RST = 1'b0;
    tick();
    check("sps_after_start", int'(oSPS_value), 16'h0005);
    wait_cnt1(1234, 2000);
    RST = 1'b1;
    tick();
    check("midrst_cnt1",  int'(oCNT1), 0);
    check("midrst_cnt2",  int'(oCNT2), 2000);
    check("midrst_sych1", int'(oSych1), 0);
    check("midrst_sych2", int'(oSych2), 0);
    check("midrst_sps",   int'(oSPS_value), 0);
    RST = 1'b0;
    tick();
    check("restart_sps", int'(oSPS_value), 16'h0005);
    for (int k = 0; k < 10; k++) tick();
    iENABLE = 1'b0; iSPS_target = 16'h0030;
    tick();
    check("dis_cnt1", int'(oCNT1), 0);
    check("dis_cnt2", int'(oCNT2), 2000);
    pulses = 0;
    iPERIOD = 16'd10; iPHASE = 16'd3;
    for (int k = 0; k < 50; k++) begin
      tick();
      pulses += int'(oSych1) + int'(oSych2);
    end
    check("dis_pulses", pulses, 0);
    check("dis_sps_held", int'(oSPS_value), 16'h0005);
    check("dis_cnt2_held", int'(oCNT2), 2000);
    iENABLE = 1'b1; iSPS_target = 16'h0005;
    tick();
    check("reen_sych1", int'(oSych1), 1);
    check("reen_cnt2", int'(oCNT2), 3);
    wait_sych1(100, n);
    check("reen_period", n, 10);

    // Randomized run against the model.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) iPERIOD = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) iPHASE = 16'($urandom_range(0, 14));
      if ($urandom_range(0, 9) == 0)
        iSPS_target = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 60))};
      if ($urandom_range(0, 49) == 0) iENABLE = ~iENABLE;
      RST = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
